dmem_arbiter: RTL and testbench

Shares the single-port byte-addressed data memory between two requesters: the pipeline load/store path (core port) and a program-loader/debug port. Core has priority, with a bounded-starvation guarantee for the loader. Misaligned and out-of-range accesses are rejected with an error and never reach memory. Sits between the MEM stage and `data_memory`, driving all of its control inputs and registering its combinational read data into a one-cycle-latency response.

---
 rtl/dmem_arbiter_pkg.sv | 32 +++
 rtl/dmem_arbiter_align_check.sv | 28 ++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access sizes, requester ids and
// the muxed request bundle that is handed to data_memory.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } mem_size_t;

  typedef enum logic {
    ARB_CORE   = 1'b0,
    ARB_LOADER = 1'b1
  } arb_port_t;

  typedef struct packed {
    logic        we;
    mem_size_t   size;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [2:0] size_bytes(input mem_size_t s);
    case (s)
      BYTE:      return 3'd1;
      HALF_WORD: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_align_check.sv
// Combinational legality check for one memory access: natural alignment and
// containment of every touched byte inside the 2**ADDR_WIDTH window.
module dmem_align_check
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [31:0] addr,
  input  mem_size_t   size,
  output logic        err
);

  localparam int LW = ADDR_WIDTH + 1;

  logic          misalign;
  logic          hi_nz;
  logic [LW-1:0] last_byte;

  always_comb begin
    misalign  = ((size == HALF_WORD) && addr[0]) ||
                ((size == WORD) && (addr[1:0] != 2'b00));
    hi_nz     = (addr >> ADDR_WIDTH) != 32'd0;
    // carry out of the window means the access runs past the top byte
    last_byte = {1'b0, addr[ADDR_WIDTH-1:0]} + LW'(size_bytes(size)) - LW'(1);
    err       = misalign || hi_nz || last_byte[ADDR_WIDTH];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for the single-port data memory: core-priority
// arbitration with bounded loader starvation, error filtering, 1-cycle response.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // core port
  input  logic        c_req_valid,
  output logic        c_req_ready,
  input  logic        c_req_we,
  input  mem_size_t   c_req_size,
  input  logic        c_req_zext,
  input  logic [31:0] c_req_addr,
  input  logic [31:0] c_req_wdata,
  output logic        c_resp_valid,
  output logic [31:0] c_resp_rdata,
  output logic        c_resp_err,
  // loader port
  input  logic        l_req_valid,
  output logic        l_req_ready,
  input  logic        l_req_we,
  input  mem_size_t   l_req_size,
  input  logic        l_req_zext,
  input  logic [31:0] l_req_addr,
  input  logic [31:0] l_req_wdata,
  output logic        l_resp_valid,
  output logic [31:0] l_resp_rdata,
  output logic        l_resp_err,
  // memory side
  output logic        dmem_reg,
  output logic        dmem_wr_en,
  output mem_size_t   dmem_data_size,
  output logic        dmem_zero_extend,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wr_data,
  input  logic [31:0] dmem_rd_data
);

  localparam int            CW    = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  dmem_req_t     c_req, l_req, sel_req;
  logic          gnt_c, gnt_l, gnt_any;
  logic          chk_err, acc_ok;

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          resp_vld_q, resp_vld_d;
  logic          resp_err_q, resp_err_d;
  arb_port_t     resp_port_q, resp_port_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  assign c_req = '{we: c_req_we, size: c_req_size, zext: c_req_zext,
                   addr: c_req_addr, wdata: c_req_wdata};
  assign l_req = '{we: l_req_we, size: l_req_size, zext: l_req_zext,
                   addr: l_req_addr, wdata: l_req_wdata};

  // loader wins only once the core has had STARVE_LIMIT grants in a row
  always_comb begin
    gnt_l       = l_req_valid && (!c_req_valid || (starve_cnt_q == LIMIT));
    gnt_c       = c_req_valid && !gnt_l;
    gnt_any     = gnt_c || gnt_l;
    sel_req     = gnt_l ? l_req : c_req;
    c_req_ready = gnt_c;
    l_req_ready = gnt_l;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!l_req_valid || gnt_l)
      starve_cnt_d = '0;
    else if (gnt_c && (starve_cnt_q != LIMIT))
      starve_cnt_d = starve_cnt_q + CW'(1);
  end

  dmem_align_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_align_check (
    .addr (sel_req.addr),
    .size (sel_req.size),
    .err  (chk_err)
  );

  always_comb begin
    acc_ok           = gnt_any && !chk_err;
    dmem_reg         = acc_ok;
    dmem_wr_en       = acc_ok && sel_req.we;
    dmem_data_size   = acc_ok ? sel_req.size : BYTE;
    dmem_zero_extend = acc_ok && sel_req.zext;
    dmem_addr        = acc_ok ? sel_req.addr  : 32'd0;
    dmem_wr_data     = acc_ok ? sel_req.wdata : 32'd0;
  end

  always_comb begin
    resp_vld_d   = gnt_any;
    resp_port_d  = gnt_l ? ARB_LOADER : ARB_CORE;
    resp_err_d   = gnt_any && chk_err;
    resp_rdata_d = (acc_ok && !sel_req.we) ? dmem_rd_data : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      resp_vld_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_port_q  <= ARB_CORE;
      resp_rdata_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_vld_q   <= resp_vld_d;
      resp_err_q   <= resp_err_d;
      resp_port_q  <= resp_port_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    c_resp_valid = resp_vld_q && (resp_port_q == ARB_CORE);
    l_resp_valid = resp_vld_q && (resp_port_q == ARB_LOADER);
    c_resp_err   = c_resp_valid && resp_err_q;
    l_resp_err   = l_resp_valid && resp_err_q;
    c_resp_rdata = c_resp_valid ? resp_rdata_q : 32'd0;
    l_resp_rdata = l_resp_valid ? resp_rdata_q : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural little-endian data_memory stand-in;
// expected responses are queued at grant time and matched as they emerge.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req_valid, c_req_ready, c_req_we, c_req_zext;
  mem_size_t   c_req_size;
  logic [31:0] c_req_addr, c_req_wdata, c_resp_rdata;
  logic        c_resp_valid, c_resp_err;
  logic        l_req_valid, l_req_ready, l_req_we, l_req_zext;
  mem_size_t   l_req_size;
  logic [31:0] l_req_addr, l_req_wdata, l_resp_rdata;
  logic        l_resp_valid, l_resp_err;
  logic        dmem_reg, dmem_wr_en, dmem_zero_extend;
  mem_size_t   dmem_data_size;
  logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_size(c_req_size), .c_req_zext(c_req_zext), .c_req_addr(c_req_addr),
    .c_req_wdata(c_req_wdata), .c_resp_valid(c_resp_valid),
    .c_resp_rdata(c_resp_rdata), .c_resp_err(c_resp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
    .l_req_size(l_req_size), .l_req_zext(l_req_zext), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_resp_valid(l_resp_valid),
    .l_resp_rdata(l_resp_rdata), .l_resp_err(l_resp_err),
    .dmem_reg(dmem_reg), .dmem_wr_en(dmem_wr_en), .dmem_data_size(dmem_data_size),
    .dmem_zero_extend(dmem_zero_extend), .dmem_addr(dmem_addr),
    .dmem_wr_data(dmem_wr_data), .dmem_rd_data(dmem_rd_data)
  );

  // behavioural data_memory: combinational read, write at clock edge
  logic [7:0]  mem [0:65535];
  logic [15:0] ma, ma1, ma2, ma3;

  always_comb begin
    ma  = dmem_addr[15:0];
    ma1 = ma + 16'd1;
    ma2 = ma + 16'd2;
    ma3 = ma + 16'd3;
    case (dmem_data_size)
      BYTE:      dmem_rd_data = dmem_zero_extend ? {24'h0, mem[ma]}
                                                 : {{24{mem[ma][7]}}, mem[ma]};
      HALF_WORD: dmem_rd_data = dmem_zero_extend ? {16'h0, mem[ma1], mem[ma]}
                                                 : {{16{mem[ma1][7]}}, mem[ma1], mem[ma]};
      default:   dmem_rd_data = {mem[ma3], mem[ma2], mem[ma1], mem[ma]};
    endcase
  end

  always @(posedge clk) begin
    if (dmem_reg && dmem_wr_en) begin
      mem[ma] <= dmem_wr_data[7:0];
      if (dmem_data_size != BYTE) mem[ma1] <= dmem_wr_data[15:8];
      if (dmem_data_size == WORD) begin
        mem[ma2] <= dmem_wr_data[23:16];
        mem[ma3] <= dmem_wr_data[31:24];
      end
    end
  end

  typedef struct {
    arb_port_t   port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    arb_port_t   p;
    logic        we;
    mem_size_t   sz;
    logic        zx;
    logic [31:0] a;
    logic [31:0] d;
    logic        err;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // response monitor: every response must match the oldest queued expectation
  exp_t        mon_e;
  arb_port_t   mon_p;
  logic        mon_err;
  logic [31:0] mon_rd;

  always @(negedge clk) begin
    if (!rst && (c_resp_valid || l_resp_valid)) begin
      n_vec++;
      mon_p   = l_resp_valid ? ARB_LOADER : ARB_CORE;
      mon_err = l_resp_valid ? l_resp_err : c_resp_err;
      mon_rd  = l_resp_valid ? l_resp_rdata : c_resp_rdata;
      if (c_resp_valid && l_resp_valid) begin
        n_bad++;
        $display("FAIL resp_onehot: both resp_valid high, required one");
      end
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: port=%0d err=%b rdata=%h, required no response",
                 mon_p, mon_err, mon_rd);
      end else begin
        mon_e = sb.pop_front();
        if (mon_p !== mon_e.port || mon_err !== mon_e.err || mon_rd !== mon_e.rdata) begin
          n_bad++;
          $display("FAIL resp_check: got port=%0d err=%b rdata=%h, required port=%0d err=%b rdata=%h",
                   mon_p, mon_err, mon_rd, mon_e.port, mon_e.err, mon_e.rdata);
        end
      end
    end
  end

  task automatic idle();
    c_req_valid = 1'b0; l_req_valid = 1'b0;
    c_req_we = 1'b0; c_req_size = BYTE; c_req_zext = 1'b0; c_req_addr = '0; c_req_wdata = '0;
    l_req_we = 1'b0; l_req_size = BYTE; l_req_zext = 1'b0; l_req_addr = '0; l_req_wdata = '0;
  endtask

  task automatic drive(input vec_t v);
    c_req_valid = (v.p == ARB_CORE);
    l_req_valid = (v.p == ARB_LOADER);
    c_req_we = v.we; c_req_size = v.sz; c_req_zext = v.zx; c_req_addr = v.a; c_req_wdata = v.d;
    l_req_we = v.we; l_req_size = v.sz; l_req_zext = v.zx; l_req_addr = v.a; l_req_wdata = v.d;
  endtask

  task automatic both_load();
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_size = WORD; c_req_zext = 1'b0;
    c_req_addr = 32'h10; c_req_wdata = '0;
    l_req_valid = 1'b1; l_req_we = 1'b0; l_req_size = WORD; l_req_zext = 1'b0;
    l_req_addr = 32'h0; l_req_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({c_resp_valid, l_resp_valid, c_resp_err, l_resp_err} !== 4'b0 ||
        c_resp_rdata !== 32'h0 || l_resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_resp: valid=%b%b err=%b%b rdata=%h/%h, required all 0",
               c_resp_valid, l_resp_valid, c_resp_err, l_resp_err, c_resp_rdata, l_resp_rdata);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({c_req_ready, l_req_ready, dmem_reg} !== 3'b0) begin
      n_bad++;
      $display("FAIL idle_cycle: ready=%b%b dmem_reg=%b, required 000",
               c_req_ready, l_req_ready, dmem_reg);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_after_store();
    vec_t t [2];
    exp_t e;
    logic rdy;
    t[0] = '{ARB_LOADER, 1'b1, WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    t[1] = '{ARB_CORE,   1'b0, WORD, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      rdy = (t[i].p == ARB_CORE) ? c_req_ready : l_req_ready;
      n_vec++;
      if (rdy !== 1'b1 || dmem_reg !== 1'b1 || dmem_wr_en !== t[i].we) begin
        n_bad++;
        $display("FAIL las_grant[%0d]: ready=%b dmem_reg=%b wr_en=%b, required 1/1/%b",
                 i, rdy, dmem_reg, dmem_wr_en, t[i].we);
      end
      e = '{t[i].p, t[i].err, t[i].exp};
      sb.push_back(e);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_sign_ext();
    vec_t t [6];
    exp_t e;
    logic rdy;
    t[0] = '{ARB_LOADER, 1'b1, BYTE,      1'b0, 32'h30, 32'h00000080, 1'b0, 32'h0};
    t[1] = '{ARB_LOADER, 1'b1, HALF_WORD, 1'b0, 32'h40, 32'h00008001, 1'b0, 32'h0};
    t[2] = '{ARB_CORE,   1'b0, BYTE,      1'b0, 32'h30, 32'h0, 1'b0, 32'hFFFFFF80};
    t[3] = '{ARB_CORE,   1'b0, BYTE,      1'b1, 32'h30, 32'h0, 1'b0, 32'h00000080};
    t[4] = '{ARB_CORE,   1'b0, HALF_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'hFFFF8001};
    t[5] = '{ARB_CORE,   1'b0, HALF_WORD, 1'b1, 32'h40, 32'h0, 1'b0, 32'h00008001};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      rdy = (t[i].p == ARB_CORE) ? c_req_ready : l_req_ready;
      n_vec++;
      if (rdy !== 1'b1 || dmem_reg !== 1'b1 || dmem_zero_extend !== t[i].zx) begin
        n_bad++;
        $display("FAIL sext_grant[%0d]: ready=%b dmem_reg=%b zext=%b, required 1/1/%b",
                 i, rdy, dmem_reg, dmem_zero_extend, t[i].zx);
      end
      e = '{t[i].p, t[i].err, t[i].exp};
      sb.push_back(e);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    vec_t t [9];
    exp_t e;
    logic rdy;
    t[0] = '{ARB_LOADER, 1'b1, WORD,      1'b0, 32'h0,       32'hCAFEF00D, 1'b0, 32'h0};
    t[1] = '{ARB_LOADER, 1'b1, WORD,      1'b0, 32'hFFFC,    32'h12345678, 1'b0, 32'h0};
    t[2] = '{ARB_CORE,   1'b1, WORD,      1'b0, 32'h2,       32'h11111111, 1'b1, 32'h0};
    t[3] = '{ARB_CORE,   1'b0, BYTE,      1'b0, 32'h10000,   32'h0, 1'b1, 32'h0};
    t[4] = '{ARB_CORE,   1'b0, HALF_WORD, 1'b0, 32'h11,      32'h0, 1'b1, 32'h0};
    t[5] = '{ARB_CORE,   1'b0, WORD,      1'b0, 32'hFFFE,    32'h0, 1'b1, 32'h0};
    t[6] = '{ARB_CORE,   1'b0, WORD,      1'b0, 32'h0,       32'h0, 1'b0, 32'hCAFEF00D};
    t[7] = '{ARB_CORE,   1'b0, WORD,      1'b0, 32'hFFFC,    32'h0, 1'b0, 32'h12345678};
    t[8] = '{ARB_CORE,   1'b0, BYTE,      1'b1, 32'hFFFF,    32'h0, 1'b0, 32'h00000012};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      rdy = (t[i].p == ARB_CORE) ? c_req_ready : l_req_ready;
      n_vec++;
      if (rdy !== 1'b1 || dmem_reg !== !t[i].err ||
          (t[i].err && (dmem_wr_en !== 1'b0 || dmem_addr !== 32'h0))) begin
        n_bad++;
        $display("FAIL err_grant[%0d]: ready=%b dmem_reg=%b wr_en=%b addr=%h, required ready=1 dmem_reg=%b",
                 i, rdy, dmem_reg, dmem_wr_en, dmem_addr, !t[i].err);
      end
      e = '{t[i].p, t[i].err, t[i].exp};
      sb.push_back(e);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    vec_t t [4];
    exp_t e;
    logic rdy;
    t[0] = '{ARB_CORE,   1'b1, HALF_WORD, 1'b0, 32'h20, 32'h00001234, 1'b0, 32'h0};
    t[1] = '{ARB_CORE,   1'b0, HALF_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00001234};
    t[2] = '{ARB_CORE,   1'b1, WORD,      1'b0, 32'h24, 32'hA5A5A5A5, 1'b0, 32'h0};
    t[3] = '{ARB_LOADER, 1'b0, WORD,      1'b0, 32'h24, 32'h0, 1'b0, 32'hA5A5A5A5};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      rdy = (t[i].p == ARB_CORE) ? c_req_ready : l_req_ready;
      n_vec++;
      if (rdy !== 1'b1 || dmem_reg !== 1'b1 || dmem_addr !== t[i].a) begin
        n_bad++;
        $display("FAIL b2b_grant[%0d]: ready=%b dmem_reg=%b addr=%h, required 1/1/%h",
                 i, rdy, dmem_reg, dmem_addr, t[i].a);
      end
      e = '{t[i].p, t[i].err, t[i].exp};
      sb.push_back(e);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    logic [9:0] pat;
    logic       exp_l;
    exp_t       e;
    pat = 10'b10000_10000;  // bit k set: loader expected in cycle k
    both_load();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_l = pat[k];
      n_vec++;
      if (c_req_ready !== !exp_l || l_req_ready !== exp_l) begin
        n_bad++;
        $display("FAIL starve_grant[%0d]: ready c=%b l=%b, required c=%b l=%b",
                 k, c_req_ready, l_req_ready, !exp_l, exp_l);
      end
      e = exp_l ? '{ARB_LOADER, 1'b0, 32'hCAFEF00D} : '{ARB_CORE, 1'b0, 32'hDEADBEEF};
      sb.push_back(e);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [4:0] pat;
    logic       exp_l;
    exp_t       e;
    both_load();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (c_req_ready !== 1'b1 || l_req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL pre_rst_grant[%0d]: ready c=%b l=%b, required c=1 l=0",
                 k, c_req_ready, l_req_ready);
      end
      // the last grant's response is expected to be dropped by reset
      if (k < 2) begin
        e = '{ARB_CORE, 1'b0, 32'hDEADBEEF};
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    idle();
    @(negedge clk);
    n_vec++;
    if (c_resp_valid !== 1'b0 || l_resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_drop: resp_valid c=%b l=%b, required 0/0", c_resp_valid, l_resp_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    pat = 5'b10000;
    both_load();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_l = pat[k];
      n_vec++;
      if (c_req_ready !== !exp_l || l_req_ready !== exp_l) begin
        n_bad++;
        $display("FAIL post_rst_grant[%0d]: ready c=%b l=%b, required c=%b l=%b",
                 k, c_req_ready, l_req_ready, !exp_l, exp_l);
      end
      e = exp_l ? '{ARB_LOADER, 1'b0, 32'hCAFEF00D} : '{ARB_CORE, 1'b0, 32'hDEADBEEF};
      sb.push_back(e);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_after_store();
    test_sign_ext();
    test_errors();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
